// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive frame checker.
//   par_typ_e : parity modes as encoded on PAR_TYP
//   state_e   : frame checker FSM states
//   expected_parity() : parity bit value the line should carry for a given mode
package uart_rx_pkg;

  typedef enum logic [1:0] {
    ParEven  = 2'b00,
    ParOdd   = 2'b01,
    ParMark  = 2'b10,
    ParSpace = 2'b11
  } par_typ_e;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StData   = 2'b01,
    StParity = 2'b10,
    StStop   = 2'b11
  } state_e;

  // acc is the XOR of all data bits received so far.
  function automatic logic expected_parity(par_typ_e typ, logic acc);
    logic exp_bit;
    unique case (typ)
      ParEven:  exp_bit = acc;
      ParOdd:   exp_bit = ~acc;
      ParMark:  exp_bit = 1'b1;
      ParSpace: exp_bit = 1'b0;
      default:  exp_bit = 1'b0;
    endcase
    return exp_bit;
  endfunction

endpackage

// File: rtl/rx_frame_check_if.sv
// Bit-stream in / frame-result out bundle of the frame checker.
//   frame_start, bit_valid, sampled_bit : from the bit sampler (master drives)
//   P_Data, frame_done, par_error, stp_error : frame results (slave drives)
interface rx_frame_check_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic                  frame_start;
  logic                  bit_valid;
  logic                  sampled_bit;
  logic [DATA_WIDTH-1:0] P_Data;
  logic                  frame_done;
  logic                  par_error;
  logic                  stp_error;

  modport master (
    output frame_start, bit_valid, sampled_bit,
    input  P_Data, frame_done, par_error, stp_error
  );

  modport slave (
    input  frame_start, bit_valid, sampled_bit,
    output P_Data, frame_done, par_error, stp_error
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   CLK, RST : clock, asynchronous active-high reset
//   clr      : synchronous clear, wins over inc
//   inc      : add one unless already at all-ones
//   count    : current value
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/rx_frame_check.sv
// UART receive frame checker: assembles DATA_WIDTH data bits (LSB first), checks the
// optional parity bit and the stop bit, and keeps saturating error counters.
//   CLK, RST      : clock, asynchronous active-high reset
//   PAR_EN        : frame carries a parity bit (latched at frame_start)
//   PAR_TYP       : parity mode (latched at frame_start)
//   err_clr       : synchronous clear of both counters
//   rx            : bit-stream inputs and frame results
//   par_err_cnt   : frames completed with a parity error
//   stp_err_cnt   : frames completed with a stop error
module rx_frame_check
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 PAR_EN,
  input  logic [1:0]           PAR_TYP,
  input  logic                 err_clr,
  rx_frame_check_if.slave      rx,
  output logic [CNT_WIDTH-1:0] par_err_cnt,
  output logic [CNT_WIDTH-1:0] stp_err_cnt
);

  localparam int unsigned BitCntW = $clog2(DATA_WIDTH + 1);

  state_e                state_q, state_d;
  logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic                  acc_q, acc_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  par_typ_e              par_typ_q, par_typ_d;
  logic                  par_bad_q, par_bad_d;   // parity verdict of the frame in flight
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  done_q, done_d;
  logic                  par_error_q, par_error_d;
  logic                  stp_error_q, stp_error_d;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    acc_d       = acc_q;
    shift_d     = shift_q;
    par_en_d    = par_en_q;
    par_typ_d   = par_typ_q;
    par_bad_d   = par_bad_q;
    data_out_d  = data_out_q;
    done_d      = 1'b0;
    par_error_d = par_error_q;
    stp_error_d = stp_error_q;

    // A start pulse restarts from any state and swallows a coincident bit strobe.
    if (rx.frame_start) begin
      state_d   = StData;
      bit_cnt_d = '0;
      acc_d     = 1'b0;
      par_en_d  = PAR_EN;
      par_typ_d = par_typ_e'(PAR_TYP);
      par_bad_d = 1'b0;
    end else if (rx.bit_valid) begin
      unique case (state_q)
        StIdle: ;
        StData: begin
          shift_d   = {rx.sampled_bit, shift_q[DATA_WIDTH-1:1]};
          acc_d     = acc_q ^ rx.sampled_bit;
          bit_cnt_d = bit_cnt_q + BitCntW'(1);
          if (bit_cnt_q == BitCntW'(DATA_WIDTH - 1)) begin
            state_d = par_en_q ? StParity : StStop;
          end
        end
        StParity: begin
          par_bad_d = rx.sampled_bit != expected_parity(par_typ_q, acc_q);
          state_d   = StStop;
        end
        StStop: begin
          state_d     = StIdle;
          done_d      = 1'b1;
          data_out_d  = shift_q;
          par_error_d = par_en_q & par_bad_q;
          stp_error_d = ~rx.sampled_bit;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      acc_q       <= 1'b0;
      shift_q     <= '0;
      par_en_q    <= 1'b0;
      par_typ_q   <= ParEven;
      par_bad_q   <= 1'b0;
      data_out_q  <= '0;
      done_q      <= 1'b0;
      par_error_q <= 1'b0;
      stp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      acc_q       <= acc_d;
      shift_q     <= shift_d;
      par_en_q    <= par_en_d;
      par_typ_q   <= par_typ_d;
      par_bad_q   <= par_bad_d;
      data_out_q  <= data_out_d;
      done_q      <= done_d;
      par_error_q <= par_error_d;
      stp_error_q <= stp_error_d;
    end
  end

  assign rx.P_Data     = data_out_q;
  assign rx.frame_done = done_q;
  assign rx.par_error  = par_error_q;
  assign rx.stp_error  = stp_error_q;

  // Counters step on the edge that ends the frame_done cycle, so an err_clr held
  // during frame_done meets the increment on the same edge and wins.
  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_par_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (err_clr),
    .inc  (done_q & par_error_q),
    .count(par_err_cnt)
  );

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_stp_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (err_clr),
    .inc  (done_q & stp_error_q),
    .count(stp_err_cnt)
  );

endmodule

// File: tb/tb_rx_frame_check.sv
// Bench for rx_frame_check: two instances (8-bit data / 8-bit counters and
// 7-bit data / 2-bit counters) driven by directed frames. A frame-level model
// predicts results from the bits sent; a per-cycle process compares against it.
module tb_rx_frame_check;

  logic       clk = 1'b0;
  logic       rst;
  logic       fs[2], bv[2], sb[2], pen[2], clr[2];
  logic [1:0] ptyp[2];
  logic [7:0] pcnt0, scnt0;
  logic [1:0] pcnt1, scnt1;

  always #5 clk = ~clk;

  rx_frame_check_if #(.DATA_WIDTH(8)) u_if0 ();
  rx_frame_check_if #(.DATA_WIDTH(7)) u_if1 ();

  assign u_if0.frame_start = fs[0];
  assign u_if0.bit_valid   = bv[0];
  assign u_if0.sampled_bit = sb[0];
  assign u_if1.frame_start = fs[1];
  assign u_if1.bit_valid   = bv[1];
  assign u_if1.sampled_bit = sb[1];

  rx_frame_check #(.DATA_WIDTH(8), .CNT_WIDTH(8)) u_dut0 (
    .CLK(clk), .RST(rst), .PAR_EN(pen[0]), .PAR_TYP(ptyp[0]), .err_clr(clr[0]),
    .rx(u_if0.slave), .par_err_cnt(pcnt0), .stp_err_cnt(scnt0)
  );

  rx_frame_check #(.DATA_WIDTH(7), .CNT_WIDTH(2)) u_dut1 (
    .CLK(clk), .RST(rst), .PAR_EN(pen[1]), .PAR_TYP(ptyp[1]), .err_clr(clr[1]),
    .rx(u_if1.slave), .par_err_cnt(pcnt1), .stp_err_cnt(scnt1)
  );

  // Frame-level model
  int       nbits[2] = '{8, 7};
  int       cmax[2]  = '{255, 3};
  bit       e_done[2], e_par[2], e_stp[2], pend_p[2], pend_s[2];
  logic [8:0] e_data[2];
  int       e_pcnt[2], e_scnt[2];
  int       done_cnt[2];

  int vectors = 0;
  int errs    = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void zero_model(int d);
    e_done[d] = 0; e_par[d] = 0; e_stp[d] = 0; e_data[d] = '0;
    e_pcnt[d] = 0; e_scnt[d] = 0; pend_p[d] = 0; pend_s[d] = 0;
  endfunction

  // One clock; inputs change 1 ns after the edge, model follows the edge.
  task automatic step();
    bit cl[2];
    cl[0] = clr[0];
    cl[1] = clr[1];
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        zero_model(d);
      end else begin
        if (cl[d]) begin
          e_pcnt[d] = 0;
          e_scnt[d] = 0;
        end else begin
          if (pend_p[d] && e_pcnt[d] < cmax[d]) e_pcnt[d]++;
          if (pend_s[d] && e_scnt[d] < cmax[d]) e_scnt[d]++;
        end
        pend_p[d] = 0;
        pend_s[d] = 0;
        e_done[d] = 0;
      end
    end
  endtask

  task automatic send_bit(int d, bit b, int gap);
    bv[d] = 1'b1;
    sb[d] = b;
    step();
    bv[d] = 1'b0;
    sb[d] = 1'b0;
    repeat (gap) step();
  endtask

  task automatic start_partial(int d, int nb, bit val);
    pen[d] = 1'b1;
    fs[d]  = 1'b1;
    step();
    fs[d]  = 1'b0;
    for (int i = 0; i < nb; i++) send_bit(d, val, 0);
  endtask

  task automatic send_frame(int d, logic [8:0] data, bit p_en, logic [1:0] typ, bit par_bit,
                            bit stop, bit restart_bv, bit clr_on_done);
    logic [8:0] mask;
    int         ones;
    bit         exp_p, perr;
    mask = (9'h1 << nbits[d]) - 9'h1;
    pen[d]  = p_en;
    ptyp[d] = typ;
    fs[d]   = 1'b1;
    if (restart_bv) begin
      bv[d] = 1'b1;
      sb[d] = 1'b1;
    end
    step();
    fs[d] = 1'b0;
    bv[d] = 1'b0;
    sb[d] = 1'b0;
    // Mode inputs wander mid-frame; the latched mode must stay in force.
    pen[d]  = ~p_en;
    ptyp[d] = ~typ;
    for (int i = 0; i < nbits[d]; i++) send_bit(d, data[i], (i % 3 == 1) ? 1 : 0);
    perr = 0;
    if (p_en) begin
      ones = $countones(data & mask);
      case (typ)
        2'b00:   exp_p = (ones % 2) == 1;
        2'b01:   exp_p = (ones % 2) == 0;
        2'b10:   exp_p = 1;
        default: exp_p = 0;
      endcase
      perr = par_bit != exp_p;
      send_bit(d, par_bit, 1);
    end
    send_bit(d, stop, 0);
    e_done[d] = 1;
    e_data[d] = data & mask;
    e_par[d]  = perr;
    e_stp[d]  = ~stop;
    pend_p[d] = perr;
    pend_s[d] = ~stop;
    if (clr_on_done) clr[d] = 1'b1;
    step();
    clr[d] = 1'b0;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("done0", 32'(u_if0.frame_done), 32'(e_done[0]));
    chk("data0", 32'(u_if0.P_Data), 32'(e_data[0]));
    chk("perr0", 32'(u_if0.par_error), 32'(e_par[0]));
    chk("serr0", 32'(u_if0.stp_error), 32'(e_stp[0]));
    chk("pcnt0", 32'(pcnt0), e_pcnt[0]);
    chk("scnt0", 32'(scnt0), e_scnt[0]);
    chk("done1", 32'(u_if1.frame_done), 32'(e_done[1]));
    chk("data1", 32'(u_if1.P_Data), 32'(e_data[1]));
    chk("perr1", 32'(u_if1.par_error), 32'(e_par[1]));
    chk("serr1", 32'(u_if1.stp_error), 32'(e_stp[1]));
    chk("pcnt1", 32'(pcnt1), e_pcnt[1]);
    chk("scnt1", 32'(scnt1), e_scnt[1]);
    if (u_if0.frame_done === 1'b1) done_cnt[0]++;
    if (u_if1.frame_done === 1'b1) done_cnt[1]++;
  end

  initial begin
    int snap;
    int seq[4] = '{2, 3, 3, 0};
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      fs[d] = 0; bv[d] = 0; sb[d] = 0; pen[d] = 0; clr[d] = 0; ptyp[d] = 2'b00;
      zero_model(d);
      done_cnt[d] = 0;
    end
    repeat (2) step();
    chk("rst_data0", 32'(u_if0.P_Data), 0);
    chk("rst_done0", 32'(u_if0.frame_done), 0);
    chk("rst_scnt1", 32'(scnt1), 0);
    rst = 1'b0;
    step();

    // Even parity, 0xA5, correct parity 0
    send_frame(0, 9'h0A5, 1, 2'b00, 0, 1, 0, 0);
    chk("even_data", 32'(u_if0.P_Data), 32'h0A5);
    chk("even_perr", 32'(u_if0.par_error), 0);
    chk("even_serr", 32'(u_if0.stp_error), 0);
    chk("even_done_cnt", done_cnt[0], 1);

    // Odd parity, 0x01 with parity bit 1 -> error
    send_frame(0, 9'h001, 1, 2'b01, 1, 1, 0, 0);
    chk("odd_perr", 32'(u_if0.par_error), 1);
    chk("odd_pcnt", 32'(pcnt0), 1);

    // Mark parity with parity bit 0 -> error
    send_frame(0, 9'h03C, 1, 2'b10, 0, 1, 0, 0);
    chk("mark_perr", 32'(u_if0.par_error), 1);
    chk("mark_pcnt", 32'(pcnt0), 2);

    // Space parity with parity bit 0 -> clean
    send_frame(0, 9'h00F, 1, 2'b11, 0, 1, 0, 0);
    chk("space_perr", 32'(u_if0.par_error), 0);

    // Parity disabled, bad stop bit
    send_frame(0, 9'h055, 0, 2'b01, 0, 0, 0, 0);
    chk("nopar_perr", 32'(u_if0.par_error), 0);
    chk("nopar_scnt", 32'(scnt0), 1);

    // Abort after 4 bits; restart pulse carries a bit that must be dropped
    snap = done_cnt[0];
    start_partial(0, 4, 1);
    send_frame(0, 9'h03C, 1, 2'b00, 0, 1, 1, 0);
    chk("abort_done_cnt", done_cnt[0] - snap, 1);
    chk("abort_data", 32'(u_if0.P_Data), 32'h03C);

    // Counter clear
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    chk("clr_pcnt0", 32'(pcnt0), 0);
    chk("clr_scnt0", 32'(scnt0), 0);

    // 7-bit data, parity disabled, 0x7F with stop 0
    send_frame(1, 9'h07F, 0, 2'b00, 0, 0, 0, 0);
    chk("w7_data", 32'(u_if1.P_Data), 32'h07F);
    chk("w7_serr", 32'(u_if1.stp_error), 1);
    chk("w7_perr", 32'(u_if1.par_error), 0);
    chk("w7_scnt", 32'(scnt1), 1);

    // Saturation at 3, then err_clr held during frame_done
    for (int k = 0; k < 4; k++) begin
      send_frame(1, 9'(7'h15 + k), 0, 2'b00, 0, 0, 0, k == 3);
      chk($sformatf("sat_scnt_%0d", k), 32'(scnt1), seq[k]);
    end

    // Reset in the middle of a frame
    snap = done_cnt[0];
    start_partial(0, 3, 1);
    rst = 1'b1;
    zero_model(0);
    zero_model(1);
    repeat (2) step();
    chk("rst_mid_data0", 32'(u_if0.P_Data), 0);
    chk("rst_mid_perr0", 32'(u_if0.par_error), 0);
    chk("rst_mid_serr0", 32'(u_if0.stp_error), 0);
    rst = 1'b0;
    repeat (3) step();
    chk("rst_mid_no_done", done_cnt[0] - snap, 0);

    // Recovery: odd parity, 0x96 with correct parity 1
    send_frame(0, 9'h096, 1, 2'b01, 1, 1, 0, 0);
    chk("recover_data", 32'(u_if0.P_Data), 32'h096);
    chk("recover_perr", 32'(u_if0.par_error), 0);
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/rx_frame_check.md
RX_FRAME_CHECK -- requirements
Module: rx_frame_check

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, number of data bits per frame (legal 5..9).
REQ-002 SHALL have parameter CNT_WIDTH, default 8, width of each saturating error counter.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port PAR_EN  input  1  1 = frame carries a parity bit.
REQ-006 SHALL have port PAR_TYP  input  2  parity mode: 00 even, 01 odd, 10 mark (expect 1), 11 space (expect 0).
REQ-007 SHALL have port frame_start  input  1  one-cycle pulse; a start bit has been validated.
REQ-008 SHALL have port bit_valid  input  1  one-cycle strobe; sampled_bit holds the next frame bit.
REQ-009 SHALL have port sampled_bit  input  1  majority-sampled serial bit.
REQ-010 SHALL have port err_clr  input  1  synchronous clear of both error counters.
REQ-011 SHALL have port P_Data  output  DATA_WIDTH  received data, LSB first on the line.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse; P_Data and error flags are valid.
REQ-013 SHALL have port par_error  output  1  parity mismatch in the last completed frame.
REQ-014 SHALL have port stp_error  output  1  stop bit sampled as 0 in the last completed frame.
REQ-015 SHALL have port par_err_cnt  output  CNT_WIDTH  saturating count of frames with par_error.
REQ-016 SHALL have port stp_err_cnt  output  CNT_WIDTH  saturating count of frames with stp_error.

Function
REQ-017 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-018 IDLE: on frame_start go to DATA, clear bit counter and parity accumulator, and latch PAR_EN/PAR_TYP for the whole frame.
REQ-019 DATA: each bit_valid shifts sampled_bit into the shift register (LSB first), XORs it into the accumulator, and increments the bit counter; after bit DATA_WIDTH, go to PARITY if latched PAR_EN = 1, else STOP.
REQ-020 PARITY: on bit_valid, compute the frame parity error as sampled_bit != expected, where expected = acc (even), ~acc (odd), 1 (mark), 0 (space); go to STOP.
REQ-021 STOP: on bit_valid, compute the stop error = ~sampled_bit, return to IDLE, and assert frame_done exactly one cycle after that strobe.
REQ-022 Together with frame_done, the block SHALL update P_Data, par_error and stp_error; all three hold until the next frame_done.
REQ-023 With parity disabled, par_error SHALL read 0 for that frame.
REQ-024 Cycles without bit_valid SHALL leave FSM, counter and accumulator unchanged.
REQ-025 frame_start in any non-IDLE state SHALL abort the current frame with no frame_done and no counter update, then restart as in REQ-018.
REQ-026 frame_start and bit_valid in the same cycle: frame_start wins and the bit is discarded.
REQ-027 Counters increment by 1 in the frame_done cycle when the matching flag is set, and saturate at 2^CNT_WIDTH-1 (no wrap).
REQ-028 err_clr coincident with an increment: the clear wins and the counter becomes 0.
REQ-029 Changes on PAR_EN/PAR_TYP mid-frame SHALL have no effect until the next frame_start.

Reset
REQ-030 While RST = 1, the block SHALL hold: FSM IDLE, P_Data 0, frame_done 0, par_error 0, stp_error 0, both counters 0, latched mode 0.
REQ-031 RST asserted mid-frame SHALL discard the frame immediately with no frame_done.

Structure
REQ-032 The PAR_TYP encodings and FSM state encoding SHALL reside in shared package uart_rx_pkg.
REQ-033 The saturating counter SHALL be a sub-module sat_counter (params WIDTH; ports CLK, RST, clr, inc, count), instantiated twice.

Verification
REQ-034 Even parity, 8 bits, data 0xA5, parity 0, stop 1 -> P_Data=0xA5, par_error=0, stp_error=0, frame_done one cycle after the stop strobe.
REQ-035 Odd parity, data 0x01, parity 1 -> par_error=1, par_err_cnt increments 0->1; mark mode with parity 0 -> par_error=1.
REQ-036 Parity disabled, DATA_WIDTH=7, data 0x7F, stop 0 -> stp_error=1, par_error=0, stp_err_cnt=1.
REQ-037 CNT_WIDTH=2, four consecutive stop-error frames -> stp_err_cnt sequence 1,2,3,3; err_clr on the fourth frame_done -> 0.
REQ-038 frame_start after 4 data bits, then a clean frame with data 0x3C -> only one frame_done and P_Data=0x3C; RST at bit 3 -> no frame_done, all outputs 0.
